// File: rtl/image_line_pkg.sv
// Shared types and helpers for the image line player.
package image_line_pkg;

   // Bits in one pixel word (all channels packed).
   function automatic int PIXEL_W(input int data_width, input int channels);
      return data_width * channels;
   endfunction

   // Selects one of the two line banks.
   typedef logic bank_sel_t;

   // Source of the pixels for the line that is starting.
   typedef enum logic [1:0] {
      SRC_NEW,
      SRC_REPEAT,
      SRC_BLANK
   } line_src_e;

endpackage

// File: rtl/image_line_bank.sv
// Ping-pong line storage: two simple dual-port RAMs, one written (fill),
// one read (play). The read port is registered, so data appears one cycle
// after the address is presented.
module image_line_bank
   import image_line_pkg::*;
#(
   parameter int PW    = 24,
   parameter int DEPTH = 1920,
   parameter int AW    = 11
) (
   input  logic          clk,
   input  logic          we,
   input  bank_sel_t     wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [PW-1:0] wr_data,
   input  logic          re,
   input  bank_sel_t     rd_bank,
   input  logic [AW-1:0] rd_addr,
   output logic [PW-1:0] rd_data
);

   logic [PW-1:0] r_mem0 [DEPTH];
   logic [PW-1:0] r_mem1 [DEPTH];
   logic [PW-1:0] r_rd_data;

   // Write port for bank 0; the caller guarantees wr_addr < DEPTH.
   always_ff @(posedge clk) begin
      if (we && (wr_bank == 1'b0)) r_mem0[wr_addr] <= wr_data;
   end

   // Write port for bank 1.
   always_ff @(posedge clk) begin
      if (we && (wr_bank == 1'b1)) r_mem1[wr_addr] <= wr_data;
   end

   // Registered read from the selected play bank.
   always_ff @(posedge clk) begin
      if (re) r_rd_data <= rd_bank ? r_mem1[rd_addr] : r_mem0[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/image_line_player.sv
// Replays a buffered image line pixel-by-pixel aligned to incoming DE/VS.
// Write side: wr_ready is a level; while it is 1 the fill bank accepts
// wr_en writes and one wr_commit. A commit makes the line pending and drops
// wr_ready until the next DE rise swaps banks. Writes/commits seen while
// wr_ready=0 are dropped.
module image_line_player
   import image_line_pkg::*;
#(
   parameter int DATA_WIDTH         = 8,
   parameter int CHANNELS           = 3,
   parameter int MAX_PIXELS         = 1920,
   parameter int REPEAT_ON_UNDERRUN = 1
) (
   input  logic                               pclk,
   input  logic                               rst_n,
   input  logic                               wr_en,
   input  logic [$clog2(MAX_PIXELS)-1:0]      wr_addr,
   input  logic [CHANNELS*DATA_WIDTH-1:0]     wr_data,
   input  logic                               wr_commit,
   input  logic [$clog2(MAX_PIXELS+1)-1:0]    wr_len,
   output logic                               wr_ready,
   input  logic                               vs_in,
   input  logic                               de_in,
   output logic                               vs_out,
   output logic                               de_out,
   output logic [CHANNELS*DATA_WIDTH-1:0]     data_out,
   output logic [15:0]                        line_cnt,
   output logic                               underrun,
   output logic                               overrun
);

   localparam int PW = PIXEL_W(DATA_WIDTH, CHANNELS);
   localparam int AW = $clog2(MAX_PIXELS);
   localparam int LW = $clog2(MAX_PIXELS + 1);

   logic            r_de_d;
   logic            r_vs_d;
   bank_sel_t       r_play;
   logic            r_pending;
   logic [LW-1:0]   r_fill_len;
   logic [LW-1:0]   r_play_len;
   logic            r_has_line;
   line_src_e       r_src;
   logic [AW-1:0]   r_ii;
   logic            r_past_end;
   logic            r_pix_valid;
   logic            r_underrun;
   logic            r_overrun;
   logic [15:0]     r_line_cnt;

   logic            w_de_rise;
   logic            w_vs_rise;
   logic            w_swap;
   line_src_e       w_start_src;
   line_src_e       w_src;
   bank_sel_t       w_rd_bank;
   logic [LW-1:0]   w_len;
   logic [AW-1:0]   w_idx;
   logic            w_past;
   logic            w_over;
   logic            w_last;
   logic [AW-1:0]   w_ii_next;
   logic            w_wr_ok;
   logic [LW-1:0]   w_clamp_len;
   logic [PW-1:0]   w_rd_data;

   assign w_de_rise = de_in & ~r_de_d;
   assign w_vs_rise = vs_in & ~r_vs_d;
   assign w_swap    = w_de_rise & r_pending;
   assign w_wr_ok   = wr_en & ~r_pending & (LW'(wr_addr) < LW'(MAX_PIXELS));
   assign w_clamp_len = (wr_len > LW'(MAX_PIXELS)) ? LW'(MAX_PIXELS) : wr_len;

   // Line-start decision and the per-pixel read/overrun terms. On the DE
   // rise cycle the read already uses the post-swap bank and index 0 so the
   // first pixel lands one cycle later.
   always_comb begin
      w_start_src = SRC_BLANK;
      if (r_pending) begin
         w_start_src = SRC_NEW;
      end else if ((REPEAT_ON_UNDERRUN != 0) && r_has_line) begin
         w_start_src = SRC_REPEAT;
      end
      w_src     = w_de_rise ? w_start_src : r_src;
      w_rd_bank = w_swap ? ~r_play : r_play;
      w_len     = w_swap ? r_fill_len : r_play_len;
      w_idx     = w_de_rise ? '0 : r_ii;
      w_past    = w_de_rise ? 1'b0 : r_past_end;
      w_over    = w_past | (LW'(w_idx) >= w_len);
      w_last    = (w_idx == AW'(MAX_PIXELS - 1));
      w_ii_next = w_last ? w_idx : w_idx + AW'(1);
   end

   // Input sync delay and edge-detect history.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_de_d <= 1'b0;
         r_vs_d <= 1'b0;
      end else begin
         r_de_d <= de_in;
         r_vs_d <= vs_in;
      end
   end

   // Pending line and bank ownership: commit fills, DE rise consumes.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= 1'b0;
         r_fill_len <= '0;
         r_play     <= 1'b0;
         r_play_len <= '0;
         r_has_line <= 1'b0;
      end else begin
         if (w_swap) begin
            r_pending  <= 1'b0;
            r_play     <= ~r_play;
            r_play_len <= r_fill_len;
            r_has_line <= 1'b1;
         end else if (wr_commit && !r_pending) begin
            r_pending  <= 1'b1;
            r_fill_len <= w_clamp_len;
         end
      end
   end

   // Pixel index, end-of-bank marker and per-line sticky flags.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_src       <= SRC_BLANK;
         r_ii        <= '0;
         r_past_end  <= 1'b0;
         r_underrun  <= 1'b0;
         r_overrun   <= 1'b0;
         r_pix_valid <= 1'b0;
      end else begin
         if (w_de_rise) begin
            r_src      <= w_start_src;
            r_underrun <= ~r_pending;
         end
         if (de_in) begin
            r_ii       <= w_ii_next;
            r_past_end <= w_past | w_last;
            r_overrun  <= (w_de_rise ? 1'b0 : r_overrun) | w_over;
         end
         r_pix_valid <= de_in & ~w_over & (w_src != SRC_BLANK);
      end
   end

   // Lines since the last VS rise; a line starting with VS counts as 1.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_cnt <= '0;
      end else if (w_vs_rise) begin
         r_line_cnt <= w_de_rise ? 16'd1 : 16'd0;
      end else if (w_de_rise) begin
         r_line_cnt <= r_line_cnt + 16'd1;
      end
   end

   image_line_bank #(
      .PW    (PW),
      .DEPTH (MAX_PIXELS),
      .AW    (AW)
   ) u_bank (
      .clk     (pclk),
      .we      (w_wr_ok),
      .wr_bank (~r_play),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .re      (de_in),
      .rd_bank (w_rd_bank),
      .rd_addr (w_idx),
      .rd_data (w_rd_data)
   );

   assign wr_ready = ~r_pending;
   assign vs_out   = r_vs_d;
   assign de_out   = r_de_d;
   assign data_out = r_pix_valid ? w_rd_data : '0;
   assign line_cnt = r_line_cnt;
   assign underrun = r_underrun;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_image_line_player.sv
// Directed bench for image_line_player. Two instances share all inputs:
// u_dut_r repeats on underrun, u_dut_b blanks on underrun.
module tb_image_line_player;

   localparam int DW   = 8;
   localparam int CH   = 3;
   localparam int MAXP = 6;
   localparam int PW   = DW * CH;
   localparam int AW   = $clog2(MAXP);
   localparam int LW   = $clog2(MAXP + 1);

   logic          pclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [PW-1:0] wr_data = '0;
   logic          wr_commit = 1'b0;
   logic [LW-1:0] wr_len = '0;
   logic          vs_in = 1'b0;
   logic          de_in = 1'b0;

   logic          wr_ready_r, vs_out_r, de_out_r, underrun_r, overrun_r;
   logic [PW-1:0] data_out_r;
   logic [15:0]   line_cnt_r;
   logic          wr_ready_b, vs_out_b, de_out_b, underrun_b, overrun_b;
   logic [PW-1:0] data_out_b;
   logic [15:0]   line_cnt_b;

   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] exp_b_q[$];

   int n_total = 0;
   int n_bad   = 0;

   // clock / reset
   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   image_line_player #(
      .DATA_WIDTH(DW), .CHANNELS(CH), .MAX_PIXELS(MAXP), .REPEAT_ON_UNDERRUN(1)
   ) u_dut_r (
      .pclk(pclk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_commit(wr_commit), .wr_len(wr_len),
      .wr_ready(wr_ready_r), .vs_in(vs_in), .de_in(de_in),
      .vs_out(vs_out_r), .de_out(de_out_r), .data_out(data_out_r),
      .line_cnt(line_cnt_r), .underrun(underrun_r), .overrun(overrun_r)
   );

   image_line_player #(
      .DATA_WIDTH(DW), .CHANNELS(CH), .MAX_PIXELS(MAXP), .REPEAT_ON_UNDERRUN(0)
   ) u_dut_b (
      .pclk(pclk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_commit(wr_commit), .wr_len(wr_len),
      .wr_ready(wr_ready_b), .vs_in(vs_in), .de_in(de_in),
      .vs_out(vs_out_b), .de_out(de_out_b), .data_out(data_out_b),
      .line_cnt(line_cnt_b), .underrun(underrun_b), .overrun(overrun_b)
   );

   // scoreboard check
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic write_px(input logic [AW-1:0] a, input logic [PW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic commit(input logic [LW-1:0] len);
      wr_commit = 1'b1; wr_len = len;
      tick();
      wr_commit = 1'b0;
   endtask

   task automatic push(input logic [PW-1:0] w_r, input logic [PW-1:0] w_b);
      exp_q.push_back(w_r);
      exp_b_q.push_back(w_b);
   endtask

   // Drives one DE line of n cycles and checks every output cycle.
   // c_first: commit together with the DE rise; c_second: try a second
   // commit in the following cycle.
   task automatic run_line(input int n, input logic exp_under, input int ov_from,
                           input logic c_first, input logic [LW-1:0] c_len,
                           input logic c_second);
      logic [PW-1:0] e_r, e_b;
      check_eq("de_out_pre", {31'd0, de_out_r}, 32'd0);
      de_in = 1'b1;
      wr_commit = c_first; wr_len = c_len;
      for (int i = 0; i < n; i++) begin
         tick();
         wr_commit = 1'b0;
         if (c_second && i == 0) begin
            wr_commit = 1'b1; wr_len = LW'(2);
         end
         if (c_first && i == 0) check_eq("wr_ready_after_commit", {31'd0, wr_ready_r}, 32'd0);
         e_r = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         e_b = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 'x;
         check_eq($sformatf("data_r[%0d]", i), {8'd0, data_out_r}, {8'd0, e_r});
         check_eq($sformatf("data_b[%0d]", i), {8'd0, data_out_b}, {8'd0, e_b});
         check_eq($sformatf("de_out[%0d]", i), {30'd0, de_out_r, de_out_b}, 32'd3);
         check_eq($sformatf("underrun[%0d]", i), {30'd0, underrun_r, underrun_b},
                  exp_under ? 32'd3 : 32'd0);
         check_eq($sformatf("overrun[%0d]", i), {30'd0, overrun_r, overrun_b},
                  (i >= ov_from) ? 32'd3 : 32'd0);
      end
      de_in = 1'b0; wr_commit = 1'b0;
      tick();
      check_eq("de_out_post", {30'd0, de_out_r, de_out_b}, 32'd0);
      check_eq("data_post", {8'd0, data_out_r | data_out_b}, 32'd0);
      tick();
      tick();
   endtask

   logic [PW-1:0] w1 [4];
   logic [PW-1:0] w3 [4];
   logic [PW-1:0] w4 [4];

   initial begin
      w1[0] = 24'h010203; w1[1] = 24'h040506; w1[2] = 24'h070809; w1[3] = 24'h0A0B0C;
      w3[0] = 24'h111111; w3[1] = 24'h222222; w3[2] = 24'h333333; w3[3] = 24'h444444;
      w4[0] = 24'hA0A1A2; w4[1] = 24'hB0B1B2; w4[2] = 24'hC0C1C2; w4[3] = 24'hD0D1D2;

      // reset state
      repeat (2) @(posedge pclk);
      #1;
      check_eq("rst_outs", {8'd0, data_out_r}, 32'd0);
      check_eq("rst_flags", {29'd0, de_out_r, vs_out_r, underrun_r | overrun_r}, 32'd0);
      check_eq("rst_line_cnt", {16'd0, line_cnt_r}, 32'd0);
      check_eq("rst_wr_ready", {30'd0, wr_ready_r, wr_ready_b}, 32'd3);
      #3 rst_n = 1'b1;
      tick();

      // first line: load, commit, play
      for (int k = 0; k < 4; k++) write_px(AW'(k), w1[k]);
      commit(LW'(4));
      check_eq("wr_ready_pending", {31'd0, wr_ready_r}, 32'd0);
      for (int k = 0; k < 4; k++) push(w1[k], w1[k]);
      run_line(4, 1'b0, 99, 1'b0, '0, 1'b0);
      check_eq("wr_ready_after_swap", {30'd0, wr_ready_r, wr_ready_b}, 32'd3);

      // underrun: repeat vs blank
      for (int k = 0; k < 4; k++) push(w1[k], '0);
      run_line(4, 1'b1, 99, 1'b0, '0, 1'b0);

      // DE longer than play length
      for (int k = 0; k < 4; k++) write_px(AW'(k), w3[k]);
      commit(LW'(4));
      for (int k = 0; k < 4; k++) push(w3[k], w3[k]);
      push('0, '0); push('0, '0);
      run_line(6, 1'b0, 4, 1'b0, '0, 1'b0);

      // commit coincident with DE rise, second commit ignored
      for (int k = 0; k < 4; k++) write_px(AW'(k), w4[k]);
      for (int k = 0; k < 4; k++) push(w3[k], '0);
      run_line(4, 1'b1, 99, 1'b1, LW'(4), 1'b1);
      check_eq("wr_ready_held", {30'd0, wr_ready_r, wr_ready_b}, 32'd0);
      for (int k = 0; k < 4; k++) push(w4[k], w4[k]);
      run_line(4, 1'b0, 99, 1'b0, '0, 1'b0);
      check_eq("wr_ready_released", {31'd0, wr_ready_r}, 32'd1);

      // length clamp and index saturation at the bank end
      for (int k = 0; k < MAXP; k++) write_px(AW'(k), 24'h100000 + PW'(k));
      commit(LW'(7));
      for (int k = 0; k < MAXP; k++) push(24'h100000 + PW'(k), 24'h100000 + PW'(k));
      push('0, '0); push('0, '0);
      run_line(MAXP + 2, 1'b0, MAXP, 1'b0, '0, 1'b0);

      // VS clears the line counter
      check_eq("line_cnt_before_vs", {16'd0, line_cnt_r}, 32'd6);
      vs_in = 1'b1;
      tick();
      check_eq("vs_clear", {16'd0, line_cnt_r}, 32'd0);
      check_eq("vs_out", {30'd0, vs_out_r, vs_out_b}, 32'd3);
      vs_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         de_in = 1'b1;
         tick();
         check_eq($sformatf("line_cnt_%0d", k), {16'd0, line_cnt_r}, 32'(k));
         de_in = 1'b0;
         tick();
      end
      vs_in = 1'b1; de_in = 1'b1;
      tick();
      check_eq("vs_with_de", {16'd0, line_cnt_r}, 32'd1);
      check_eq("vs_with_de_b", {16'd0, line_cnt_b}, 32'd1);
      vs_in = 1'b0; de_in = 1'b0;
      tick(); tick();

      // reset mid-line discards pending and line validity
      for (int k = 0; k < 4; k++) write_px(AW'(k), w1[k]);
      commit(LW'(4));
      de_in = 1'b1;
      tick();
      wr_en = 1'b1; wr_addr = '0; wr_data = 24'hFFFFFF;
      wr_commit = 1'b1; wr_len = LW'(1);
      tick();
      wr_en = 1'b0; wr_commit = 1'b0;
      check_eq("mid_line_data", {8'd0, data_out_r}, {8'd0, w1[1]});
      check_eq("mid_line_pending", {31'd0, wr_ready_r}, 32'd0);
      rst_n = 1'b0; de_in = 1'b0;
      #1;
      check_eq("async_rst_data", {8'd0, data_out_r | data_out_b}, 32'd0);
      check_eq("async_rst_de", {30'd0, de_out_r, de_out_b}, 32'd0);
      check_eq("async_rst_flags", {30'd0, underrun_r, overrun_r}, 32'd0);
      check_eq("async_rst_line_cnt", {16'd0, line_cnt_r}, 32'd0);
      check_eq("async_rst_wr_ready", {31'd0, wr_ready_r}, 32'd1);
      #2 rst_n = 1'b1;
      tick();
      check_eq("post_rst_wr_ready", {30'd0, wr_ready_r, wr_ready_b}, 32'd3);
      for (int k = 0; k < 4; k++) push('0, '0);
      run_line(4, 1'b1, 0, 1'b0, '0, 1'b0);

      // final report
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/image_line_player.md
Name: image_line_player

Overview:
- Synthesizable successor to the file-driven line replay used in image benches.
- A loader (bench file reader or upstream DMA) writes one image line into a ping-pong line buffer. The block replays it pixel-by-pixel on pclk, aligned to the incoming DE/VS timing.
- Generalised over pixel width, channel count and maximum line length.
- Adds double buffering, underrun handling (repeat or blank) and overrun flagging.

Parameters:
- DATA_WIDTH, 8, bits per channel.
- CHANNELS, 3, channels per pixel; pixel word = CHANNELS*DATA_WIDTH.
- MAX_PIXELS, 1920, maximum pixels per line (bank depth).
- REPEAT_ON_UNDERRUN, 1, 1 = replay previous line when no new line is committed; 0 = output zeros.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write one pixel into the fill bank.
- wr_addr  in  $clog2(MAX_PIXELS)  pixel index in the fill bank.
- wr_data  in  CHANNELS*DATA_WIDTH  pixel word.
- wr_commit  in  1  one-cycle pulse: fill bank holds a complete line.
- wr_len  in  $clog2(MAX_PIXELS+1)  valid pixel count, sampled with wr_commit.
- wr_ready  out  1  fill bank may be written (no pending line).
- vs_in  in  1  vertical sync.
- de_in  in  1  data enable.
- vs_out  out  1  vs_in delayed 1 cycle.
- de_out  out  1  de_in delayed 1 cycle.
- data_out  out  CHANNELS*DATA_WIDTH  pixel, valid while de_out=1, else 0.
- line_cnt  out  16  lines started since last vs_in rise.
- underrun  out  1  sticky per line: line started with no pending line.
- overrun  out  1  sticky per line: DE longer than the play length.

Behaviour:
- Reset (asynchronous): all outputs 0. Bank state is play=0, fill=1. pending=0, play_len=0, pixel counter II=0, has_line=0. wr_ready=1 after reset.
- Write side:
  - wr_en writes wr_data to the fill bank at wr_addr. Writes with wr_addr >= MAX_PIXELS are ignored.
  - wr_en while wr_ready=0 is ignored.
- Commit:
  - wr_commit with wr_ready=1 latches fill_len=min(wr_len,MAX_PIXELS) and sets pending=1. wr_ready drops on the next cycle.
  - wr_commit while pending=1 is ignored.
- Line start is a rising edge of de_in (de_in=1, previous de_in=0):
  - pending=1: swap banks, play_len=fill_len, pending=0, has_line=1, underrun=0.
  - pending=0: underrun=1 and no swap. With REPEAT_ON_UNDERRUN=1 and has_line=1, the previous line replays. Otherwise data_out is 0 for the whole line.
  - II=0, overrun=0, line_cnt increments (wraps at 2^16).
- Simultaneous wr_commit and DE rise: the start decision uses pending as registered before the edge. The commit takes effect for the next line. No loss, no swap this line.
- During DE:
  - Latency is exactly 1 cycle: data_out at cycle t+1 = play_bank[II] for de_in at cycle t. II increments per de_in cycle.
  - If II >= play_len, data_out=0 and overrun is set.
  - II saturates at MAX_PIXELS-1 and never wraps into valid data.
- DE fall: no action; data_out returns to 0 with de_out.
- VS: a rising edge of vs_in clears line_cnt to 0. The line that starts in the same cycle counts as 1.
- Reset asserted mid-line: outputs go to 0 immediately (async). Pending and both banks' validity are discarded. Bank RAM contents need not be cleared.
- Bank RAM: one synchronous read port (play) and one synchronous write port (fill). Read is addressed by II in the same cycle as de_in to meet the 1-cycle latency.

Decomposition:
- Package image_line_pkg:
  - PIXEL_W function (CHANNELS*DATA_WIDTH).
  - typedef bank_sel_t (1 bit).
  - typedef enum line_src_e {SRC_NEW, SRC_REPEAT, SRC_BLANK} for the start decision.
- Sub-module image_line_bank: two MAX_PIXELS x PIXEL_W simple dual-port RAMs with bank-select muxing on the write and read sides.
- Top holds edge detect, pending/bank control, II counter and flags.

Test Plan:
- Load pixels 0..3 = 0x010203, 0x040506, 0x070809, 0x0A0B0C; commit wr_len=4; de_in high 4 cycles -> data_out shows the four words on cycles 1..4 after DE rise; de_out is delayed 1; underrun=0, overrun=0; wr_ready=1 after the swap.
- No new commit before second DE (REPEAT=1) -> the same 4 words replay with underrun=1. Same scenario with REPEAT=0 -> data_out=0 for all 4 cycles, underrun=1.
- Commit len=4, then de_in high 6 cycles -> words 0..3, then 0, 0; overrun=1 from the 5th output pixel.
- wr_commit in the same cycle as DE rise with no prior pending -> that line is underrun. The next DE plays the new data, wr_ready=0 until then, and a second wr_commit meanwhile is ignored.
- Drive vs_in rise then 3 DE pulses -> line_cnt = 1, 2, 3; the next vs rise with DE resets line_cnt to 1.
- Assert rst_n=0 at pixel 2 of a playing line -> de_out, data_out and flags are 0 immediately. After release, wr_ready=1, and the first DE underruns with zero output.
